// File: rtl/uart_tx_ctl_pkg.sv
// Shared UART definitions: FSM state encodings, default bit period and
// frame-length helpers used by the transmit and receive controllers.
package uart_tx_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // 50 MHz system clock, 115200 baud
    localparam int DEF_BPS_DIV = 434;
    localparam int DATA_BITS   = 8;

    // Bits in one frame: start + data + optional parity + stop bits
    function automatic int frame_bits(input int parity_en, input int stop_bits);
        return 1 + DATA_BITS + parity_en + stop_bits;
    endfunction

    // Clock cycles in one frame
    function automatic int frame_cycles(input int bps_div, input int parity_en, input int stop_bits);
        return frame_bits(parity_en, stop_bits) * bps_div;
    endfunction

endpackage

// File: rtl/uart_tx_ctl_bps.sv
// Baud divider for the transmitter: counts 0..BPS_DIV-1 while enabled and
// flags the terminal count. Disabling the count clears it, so every frame
// starts on a full bit period.
module tx_bps_module
    import uart_tx_ctl_pkg::*;
#(
    parameter int BPS_DIV = DEF_BPS_DIV
)(
    input  logic CLK,
    input  logic RST,
    input  logic Count_Sig,
    output logic BPS_Tick
);

    localparam int CNT_W = (BPS_DIV > 1) ? $clog2(BPS_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(BPS_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Bit-period counter, wraps on terminal count and holds at zero when idle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (!Count_Sig) begin
            r_cnt <= '0;
        end else if (r_cnt == TERM) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign BPS_Tick = Count_Sig && (r_cnt == TERM);

endmodule

// File: rtl/uart_tx_ctl.sv
// UART transmit controller: one-deep holding register feeding a frame FSM
// (start, 8 data bits LSB first, optional parity, 1 or 2 stop bits).
// A byte held during a frame is launched on the last stop-bit tick so
// back-to-back frames have no idle gap.
module uart_tx_ctl
    import uart_tx_ctl_pkg::*;
#(
    parameter int BPS_DIV    = DEF_BPS_DIV,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
)(
    input  logic       CLK,
    input  logic       RST,
    input  logic       TX_En_Sig,
    input  logic [7:0] TX_Data,
    output logic       TX_Ready,
    output logic       TX_Busy,
    output logic       TX_Done_Sig,
    output logic       TX_Pin_Out
);

    localparam logic       PAR_ODD   = (PARITY_ODD != 0);
    localparam logic       LAST_STOP = (STOP_BITS > 1) ? 1'b1 : 1'b0;
    localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);

    tx_state_t  r_state;
    logic [7:0] r_hold;
    logic [7:0] r_shift;
    logic [2:0] r_idx;
    logic       r_stop_cnt;
    logic       r_ready;
    logic       r_busy;
    logic       r_done;
    logic       r_pin;

    logic       w_tick;
    logic       w_write;
    logic       w_last_stop;
    logic       w_load;
    logic       w_parity;

    tx_bps_module #(
        .BPS_DIV (BPS_DIV)
    ) u_bps (
        .CLK       (CLK),
        .RST       (RST),
        .Count_Sig (r_busy),
        .BPS_Tick  (w_tick)
    );

    // r_ready low means the holding register is occupied
    assign w_write     = TX_En_Sig && r_ready;
    assign w_last_stop = (r_stop_cnt == LAST_STOP);
    assign w_load      = !r_ready &&
                         ((r_state == ST_IDLE) ||
                          ((r_state == ST_STOP) && w_tick && w_last_stop));
    assign w_parity    = (^r_shift) ^ PAR_ODD;

    // Byte storage: capture on accepted write, move to shifter on frame load
    always_ff @(posedge CLK) begin
        if (w_write) begin
            r_hold <= TX_Data;
        end
        if (w_load) begin
            r_shift <= r_hold;
        end
    end

    // Frame FSM with registered pin, busy, ready and done outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_stop_cnt <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pin      <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (w_write) begin
                r_ready <= 1'b0;
            end
            if (w_load) begin
                // From STOP this edge also ends the previous frame
                if (r_state == ST_STOP) begin
                    r_done <= 1'b1;
                end
                r_ready <= 1'b1;
                r_state <= ST_START;
                r_busy  <= 1'b1;
                r_pin   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_busy <= 1'b0;
                        r_pin  <= 1'b1;
                    end
                    ST_START: begin
                        if (w_tick) begin
                            r_state <= ST_DATA;
                            r_idx   <= '0;
                            r_pin   <= r_shift[0];
                        end
                    end
                    ST_DATA: begin
                        if (w_tick) begin
                            if (r_idx == LAST_IDX) begin
                                if (PARITY_EN != 0) begin
                                    r_state <= ST_PARITY;
                                    r_pin   <= w_parity;
                                end else begin
                                    r_state    <= ST_STOP;
                                    r_stop_cnt <= 1'b0;
                                    r_pin      <= 1'b1;
                                end
                            end else begin
                                r_idx <= r_idx + 3'd1;
                                r_pin <= r_shift[r_idx + 3'd1];
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_tick) begin
                            r_state    <= ST_STOP;
                            r_stop_cnt <= 1'b0;
                            r_pin      <= 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (w_tick) begin
                            if (w_last_stop) begin
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_pin   <= 1'b1;
                            end else begin
                                r_stop_cnt <= r_stop_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_pin   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign TX_Ready    = r_ready;
    assign TX_Busy     = r_busy;
    assign TX_Done_Sig = r_done;
    assign TX_Pin_Out  = r_pin;

endmodule

// File: tb/tb_uart_tx_ctl.sv
// Testbench for uart_tx_ctl. Three instances share the write port and differ
// in frame format. Every cycle's outputs are recorded and compared against a
// frame schedule computed from the byte-accept times.
module tb_uart_tx_ctl;

    localparam int DIV  = 4;
    localparam int NCH  = 3;
    localparam int MAXE = 8192;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           en  = 1'b0;
    logic [7:0]     din = 8'h00;
    logic [NCH-1:0] ready;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;
    logic [NCH-1:0] pin;

    int pe [NCH] = '{0, 1, 1};
    int po [NCH] = '{0, 0, 1};
    int st [NCH] = '{1, 2, 1};

    int cyc     = 0;
    int seg     = 0;
    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] rec [NCH][MAXE];

    typedef struct {
        int         ch;
        int         t;
        int         L;
        logic [7:0] b;
    } frame_t;

    frame_t fq [$];
    int last_L   [NCH];
    int last_end [NCH];

    uart_tx_ctl #(.BPS_DIV(DIV), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .CLK(CLK), .RST(RST), .TX_En_Sig(en), .TX_Data(din),
        .TX_Ready(ready[0]), .TX_Busy(busy[0]), .TX_Done_Sig(done[0]), .TX_Pin_Out(pin[0]));

    uart_tx_ctl #(.BPS_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .CLK(CLK), .RST(RST), .TX_En_Sig(en), .TX_Data(din),
        .TX_Ready(ready[1]), .TX_Busy(busy[1]), .TX_Done_Sig(done[1]), .TX_Pin_Out(pin[1]));

    uart_tx_ctl #(.BPS_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .CLK(CLK), .RST(RST), .TX_En_Sig(en), .TX_Data(din),
        .TX_Ready(ready[2]), .TX_Busy(busy[2]), .TX_Done_Sig(done[2]), .TX_Pin_Out(pin[2]));

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Outputs after edge k are stored at index k
    always @(negedge CLK) begin
        if (cyc > 0 && cyc <= MAXE) begin
            for (int ch = 0; ch < NCH; ch++) begin
                rec[ch][cyc-1] <= {pin[ch], busy[ch], ready[ch], done[ch]};
            end
        end
    end

    function automatic int flen(input int ch);
        return (10 + pe[ch] + st[ch] - 1) * DIV;
    endfunction

    // Line level of bit i of a frame carrying byte b
    function automatic logic fbit(input int ch, input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (pe[ch] != 0 && i == 9) return (^b) ^ po[ch][0];
        return 1'b1;
    endfunction

    // Expected {pin, busy, ready, done} after edge k
    function automatic logic [3:0] exp_vec(input int ch, input int k);
        logic p, bz, rd, dn;
        p = 1'b1; bz = 1'b0; rd = 1'b1; dn = 1'b0;
        foreach (fq[j]) begin
            if (fq[j].ch == ch) begin
                int n;
                n = flen(ch);
                if (k >= fq[j].L && k < fq[j].L + n) begin
                    p  = fbit(ch, fq[j].b, (k - fq[j].L) / DIV);
                    bz = 1'b1;
                end
                if (k == fq[j].L + n) dn = 1'b1;
                if (k >= fq[j].t && k < fq[j].L) rd = 1'b0;
            end
        end
        return {p, bz, rd, dn};
    endfunction

    task automatic model_reset();
        fq.delete();
        for (int ch = 0; ch < NCH; ch++) begin
            last_L[ch]   = -1000;
            last_end[ch] = -1000;
        end
    endtask

    // A write on edge e is taken if the previously held byte has already left
    // the holding register; it then starts one edge later or when the
    // current frame ends, whichever is later.
    task automatic model_write(input int e, input logic [7:0] b);
        for (int ch = 0; ch < NCH; ch++) begin
            if (e > last_L[ch]) begin
                frame_t f;
                f.ch = ch;
                f.t  = e;
                f.L  = (e + 1 > last_end[ch]) ? e + 1 : last_end[ch];
                f.b  = b;
                fq.push_back(f);
                last_L[ch]   = f.L;
                last_end[ch] = f.L + flen(ch);
            end
        end
    endtask

    task automatic do_write(input logic [7:0] b);
        @(negedge CLK);
        en  = 1'b1;
        din = b;
        model_write(cyc, b);
        @(negedge CLK);
        en  = 1'b0;
    endtask

    task automatic check_window(input int a, input int b);
        int hi;
        hi = (b < MAXE) ? b : MAXE - 1;
        for (int k = a; k <= hi; k++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                logic [3:0] ex;
                ex = exp_vec(ch, k);
                n_assert++;
                assert (rec[ch][k] === ex) else begin
                    n_fail++;
                    $error("FAIL wave ch%0d edge %0d: observed pin/busy/ready/done=%b expected %b",
                           ch, k, rec[ch][k], ex);
                end
            end
        end
    endtask

    task automatic sync_check();
        @(negedge CLK);
        #1;
        check_window(seg, cyc - 1);
        seg = cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int ch = 0; ch < NCH; ch++) begin
            n_assert++;
            assert ({pin[ch], busy[ch], ready[ch], done[ch]} === 4'b1010) else begin
                n_fail++;
                $error("FAIL %s ch%0d: observed pin/busy/ready/done=%b expected 1010",
                       tag, ch, {pin[ch], busy[ch], ready[ch], done[ch]});
            end
        end
    endtask

    initial begin
        int         s;
        int         seg_rel;
        logic [7:0] rx;

        model_reset();
        repeat (2) @(posedge CLK);
        #2;
        check_reset_outputs("reset_hold");
        @(negedge CLK);
        RST = 1'b0;
        seg = cyc;

        // Idle line after reset
        repeat (100) @(negedge CLK);
        sync_check();

        // Single frame
        do_write(8'h55);
        repeat (60) @(negedge CLK);
        sync_check();

        // Back-to-back frames plus a write while the holding register is full
        do_write(8'hA5);
        repeat (10) @(negedge CLK);
        do_write(8'h3C);
        repeat (3) @(negedge CLK);
        do_write(8'hFF);
        repeat (120) @(negedge CLK);
        sync_check();

        // Parity: even gives 1, odd gives 0
        do_write(8'h07);
        repeat (60) @(negedge CLK);
        sync_check();

        // Random bytes at random spacing, including writes while full
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(0, 45)) @(negedge CLK);
            do_write(8'($urandom));
            if (r % 8 == 7) sync_check();
        end
        repeat (150) @(negedge CLK);
        sync_check();

        // Reset in the middle of a data bit
        do_write(8'h81);
        repeat (14) @(negedge CLK);
        sync_check();
        RST = 1'b1;
        #1;
        check_reset_outputs("reset_midframe");
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        seg     = cyc;
        seg_rel = cyc;

        do_write(8'h81);
        repeat (60) @(negedge CLK);
        sync_check();

        // Decode the frame from the line as a receiver would (mid-bit sampling)
        s  = -1;
        rx = 8'h00;
        for (int k = seg_rel; k < cyc - 1; k++) begin
            if (s < 0 && rec[0][k][3] == 1'b0) s = k;
        end
        n_assert++;
        assert (s >= 0) else begin
            n_fail++;
            $error("FAIL loopback_start: observed no start bit expected start bit");
        end
        if (s >= 0) begin
            for (int i = 0; i < 8; i++) begin
                rx[i] = rec[0][s + DIV/2 + (i + 1) * DIV][3];
            end
            n_assert++;
            assert (rx === 8'h81) else begin
                n_fail++;
                $error("FAIL loopback_data: observed %02h expected 81", rx);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
